merge_addr_data_tx: RTL and testbench

- Transmit-side counterpart of the DFX flit unpacker.
- Takes a payload and its destination address from the arbiter/output-port side and packs them into one DFX flit. The flit layout is address in the LSBs, data above.
- Registers the flit in a 2-entry skid FIFO with valid/ready on both sides, so backpressure never combinationally couples the input to the link.
- Sits between the router output arbiter and the DFX link driver.

---
 rtl/merge_addr_data_tx.sv | 101 ++++++++++
 tb/tb_merge_addr_data_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_addr_data_tx.sv
// Packs {data, dst_addr} into one DFX flit behind a 2-entry skid FIFO.
// Optional self-address drop enabled by MERGE_ADDR_DATA_DROP_SELF_EN.
module merge_addr_data_tx #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int CNT_WIDTH      = 16
`ifdef MERGE_ADDR_DATA_DROP_SELF_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] LOCAL_ADDR = '0
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     data_arbiter_send,
  input  logic [ADDR_WIDTH-1:0]     dst_addr_arbiter_send,
  input  logic                      valid_arbiter_send,
  output logic                      ready_arbiter_send,
  output logic [DATA_DFX_WIDTH-1:0] data_dfx_send,
  output logic                      valid_dfx_send,
  input  logic                      ready_dfx_send,
  output logic [CNT_WIDTH-1:0]      sent_cnt
`ifdef MERGE_ADDR_DATA_DROP_SELF_EN
  ,
  output logic [CNT_WIDTH-1:0]      drop_cnt
`endif
);

  logic [DATA_DFX_WIDTH-1:0] mem [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;
  logic                      push;
  logic                      pop;
  logic                      wr_en;

  // Ready depends only on stored count, never on the link side.
  assign ready_arbiter_send = (count != 2'd2);
  assign valid_dfx_send     = (count != 2'd0);
  assign data_dfx_send      = mem[rd_ptr];

  assign push = valid_arbiter_send & ready_arbiter_send;
  assign pop  = valid_dfx_send & ready_dfx_send;

`ifdef MERGE_ADDR_DATA_DROP_SELF_EN
  logic self_hit;

  assign self_hit = (dst_addr_arbiter_send == LOCAL_ADDR);
  assign wr_en    = push & ~self_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (push && self_hit) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign wr_en = push;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= {data_arbiter_send, dst_addr_arbiter_send};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else begin
      unique case ({wr_en, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt <= '0;
    end else if (pop) begin
      sent_cnt <= sent_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_merge_addr_data_tx.sv
// Bench for merge_addr_data_tx: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_merge_addr_data_tx;

  localparam int DW = 1024;
  localparam int AW = 10;
  localparam int FW = DW + AW;
  localparam int CW = 16;
  localparam logic [AW-1:0] LOCAL = 10'h005;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic [AW-1:0] ain;
  logic          vin;
  logic          rdy_in;
  logic [FW-1:0] dout;
  logic          vout;
  logic          rdy_out;
  logic [CW-1:0] sent;
  logic [CW-1:0] drop;

  int n_tests;
  int n_fail;

`ifdef MERGE_ADDR_DATA_DROP_SELF_EN
  merge_addr_data_tx #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
    .LOCAL_ADDR(LOCAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_arbiter_send(din), .dst_addr_arbiter_send(ain),
    .valid_arbiter_send(vin), .ready_arbiter_send(rdy_in),
    .data_dfx_send(dout), .valid_dfx_send(vout),
    .ready_dfx_send(rdy_out), .sent_cnt(sent), .drop_cnt(drop)
  );
  localparam bit DROP_EN = 1'b1;
`else
  merge_addr_data_tx #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_arbiter_send(din), .dst_addr_arbiter_send(ain),
    .valid_arbiter_send(vin), .ready_arbiter_send(rdy_in),
    .data_dfx_send(dout), .valid_dfx_send(vout),
    .ready_dfx_send(rdy_out), .sent_cnt(sent)
  );
  assign drop = '0;
  localparam bit DROP_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [FW-1:0] mq [$];
  logic [CW-1:0] msent;
  logic [CW-1:0] mdrop;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [7:0]    b;
    logic          r;
    logic          ev;
    logic          er;
    logic [AW-1:0] ea;
    logic [7:0]    eb;
    logic [CW-1:0] es;
  } vec_t;

  vec_t tbl [6];

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_flit(string nm, logic [FW-1:0] got,
                            logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr %0h data_lo %0h expected addr %0h data_lo %0h",
               nm, got[AW-1:0], got[AW+63:AW], exp[AW-1:0], exp[AW+63:AW]);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_check(string nm);
    check({nm, ".valid"}, 64'(vout), 64'(mq.size() != 0));
    check({nm, ".ready"}, 64'(rdy_in), 64'(mq.size() < 2));
    check({nm, ".sent"}, 64'(sent), 64'(msent));
    if (DROP_EN) check({nm, ".drop"}, 64'(drop), 64'(mdrop));
    if (mq.size() != 0) check_flit({nm, ".data"}, dout, mq[0]);
  endtask

  // one clock with given inputs; model advances on the same edge
  task automatic cycle(logic v, logic [AW-1:0] a, logic [DW-1:0] d,
                       logic r, string nm);
    logic mpush;
    logic mpop;
    vin    = v;
    ain    = v ? a : AW'($urandom);
    din    = v ? d : rnd_data();
    rdy_out = r;
    mpush  = v && (mq.size() < 2);
    mpop   = r && (mq.size() != 0);
    @(posedge clk);
    if (mpop) begin
      void'(mq.pop_front());
      msent++;
    end
    if (mpush) begin
      if (DROP_EN && a == LOCAL) mdrop++;
      else mq.push_back({d, a});
    end
    #1;
    model_check(nm);
  endtask

  task automatic do_reset();
    vin = 1'b0;
    rdy_out = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", 64'(vout), 64'(0));
    check("rst.ready", 64'(rdy_in), 64'(1));
    check("rst.sent", 64'(sent), 64'(0));
    check("rst.data", 64'(dout[63:0]), 64'(0));
    mq.delete();
    msent = '0;
    mdrop = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    vin     = 1'b0;
    ain     = '0;
    din     = '0;
    rdy_out = 1'b0;
    msent   = '0;
    mdrop   = '0;

    // backpressure vectors: push 1,2,3 with link stalled, then drain
    tbl[0] = '{1'b1, 10'd1, 8'h11, 1'b0, 1'b1, 1'b1, 10'd1, 8'h11, 16'd0};
    tbl[1] = '{1'b1, 10'd2, 8'h22, 1'b0, 1'b1, 1'b0, 10'd1, 8'h11, 16'd0};
    tbl[2] = '{1'b1, 10'd3, 8'h33, 1'b0, 1'b1, 1'b0, 10'd1, 8'h11, 16'd0};
    tbl[3] = '{1'b1, 10'd3, 8'h33, 1'b1, 1'b1, 1'b1, 10'd2, 8'h22, 16'd1};
    tbl[4] = '{1'b1, 10'd3, 8'h33, 1'b1, 1'b1, 1'b1, 10'd3, 8'h33, 16'd2};
    tbl[5] = '{1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b1, 10'd0, 8'h00, 16'd3};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      vin     = tbl[i].v;
      ain     = tbl[i].a;
      din     = {128{tbl[i].b}};
      rdy_out = tbl[i].r;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.valid", i), 64'(vout), 64'(tbl[i].ev));
      check($sformatf("tbl%0d.ready", i), 64'(rdy_in), 64'(tbl[i].er));
      check($sformatf("tbl%0d.sent", i), 64'(sent), 64'(tbl[i].es));
      if (tbl[i].ev)
        check_flit($sformatf("tbl%0d.data", i), dout,
                   {{128{tbl[i].eb}}, tbl[i].ea});
    end

    // single flit
    do_reset();
    cycle(1'b1, 10'h155, {128{8'hA5}}, 1'b1, "single");
    check("single.valid", 64'(vout), 64'(1));
    check_flit("single.flit", dout, {{128{8'hA5}}, 10'h155});
    cycle(1'b0, '0, '0, 1'b1, "single.drain");
    check("single.sent", 64'(sent), 64'(1));

    // push and pop together at count 1
    do_reset();
    cycle(1'b1, 10'h0a, rnd_data(), 1'b0, "pp.fill");
    for (int i = 0; i < 4; i++)
      cycle(1'b1, AW'(10'h10 + i), rnd_data(), 1'b1, "pp");
    check("pp.valid", 64'(vout), 64'(1));
    check("pp.ready", 64'(rdy_in), 64'(1));

    // streaming 100 flits
    do_reset();
    for (int i = 0; i < 100; i++)
      cycle(1'b1, AW'(i + 8), rnd_data(), 1'b1, "stream");
    cycle(1'b0, '0, '0, 1'b1, "stream.drain");
    check("stream.sent", 64'(sent), 64'(100));

    // asynchronous reset while full
    do_reset();
    cycle(1'b1, 10'h21, rnd_data(), 1'b0, "ar.f1");
    cycle(1'b1, 10'h22, rnd_data(), 1'b0, "ar.f2");
    cycle(1'b0, '0, '0, 1'b1, "ar.pop");
    cycle(1'b1, 10'h23, rnd_data(), 1'b0, "ar.f3");
    check("ar.full", 64'(rdy_in), 64'(0));
    do_reset();
    cycle(1'b1, 10'h31, rnd_data(), 1'b0, "ar.post1");
    cycle(1'b1, 10'h32, rnd_data(), 1'b1, "ar.post2");
    cycle(1'b0, '0, '0, 1'b1, "ar.post3");
    cycle(1'b0, '0, '0, 1'b1, "ar.post4");

    // self-address drop
    if (DROP_EN) begin
      do_reset();
      cycle(1'b1, 10'h005, rnd_data(), 1'b1, "drop1");
      cycle(1'b1, 10'h006, rnd_data(), 1'b1, "drop2");
      cycle(1'b1, 10'h005, rnd_data(), 1'b1, "drop3");
      cycle(1'b0, '0, '0, 1'b1, "drop4");
      check("drop.cnt", 64'(drop), 64'(2));
      check("drop.sent", 64'(sent), 64'(1));
    end

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? LOCAL : AW'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), ra, rnd_data(),
            1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
